password_lock_n: RTL and testbench

- Parametrised successor to the single-bit-per-step password FSM.
- Accepts a code of DIGITS entries, each DIG_W bits wide, from switches. One entry is latched per button press.
- Adds the following, which the previous block lacked:
  - an internal button synchroniser and edge detector;
  - deferred error reporting, so no early exit on a wrong digit;
  - a retry counter with timed lockout;
  - auto-relock after a successful unlock.
- Drives five active-low seven-segment displays and status flags for board-level use.

---
 rtl/password_lock_n_if.sv | 39 +++
 rtl/password_lock_n.sv | 213 +++++++++++++++++++++
 tb/tb_password_lock_n.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/password_lock_n_if.sv
// password_lock_n_if: board-side signal bundle for password_lock_n.
//   boton      - raw push button, active-high, asynchronous to clk
//   sw         - current code entry value
//   unlocked   - high only while the lock is open
//   locked_out - high only during the lockout period
//   tries_left - remaining attempts before lockout
//   digit_idx  - entries accepted in the current attempt
//   HEX0..HEX4 - active-low seven-segment digits, {g,f,e,d,c,b,a}
// master: board/testbench side. slave: the lock itself.
interface password_lock_n_if #(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned DIG_W     = 4,
  parameter int unsigned MAX_TRIES = 3
);
  localparam int unsigned TriesW = $clog2(MAX_TRIES + 1);
  localparam int unsigned IdxW   = $clog2(DIGITS + 1);

  logic              boton;
  logic [DIG_W-1:0]  sw;
  logic              unlocked;
  logic              locked_out;
  logic [TriesW-1:0] tries_left;
  logic [IdxW-1:0]   digit_idx;
  logic [6:0]        HEX0;
  logic [6:0]        HEX1;
  logic [6:0]        HEX2;
  logic [6:0]        HEX3;
  logic [6:0]        HEX4;

  modport master (
    output boton, sw,
    input  unlocked, locked_out, tries_left, digit_idx, HEX0, HEX1, HEX2, HEX3, HEX4
  );

  modport slave (
    input  boton, sw,
    output unlocked, locked_out, tries_left, digit_idx, HEX0, HEX1, HEX2, HEX3, HEX4
  );
endinterface

// File: rtl/password_lock_n.sv
// password_lock_n: multi-digit combination lock with a synchronised button, deferred error
// reporting, a retry counter with timed lockout and automatic relock after opening.
//   clk     - system clock
//   rst     - asynchronous active-high reset
//   lock_if - slave side of password_lock_n_if (button, switches, status, displays)
module password_lock_n #(
  parameter int unsigned                DIGITS      = 4,
  parameter int unsigned                DIG_W       = 4,
  parameter logic [DIGITS*DIG_W-1:0]    PASSWORD    = 16'h3A5C,
  parameter int unsigned                MAX_TRIES   = 3,
  parameter int unsigned                LOCK_CYCLES = 250000000,
  parameter int unsigned                OPEN_CYCLES = 500000000
) (
  input logic               clk,
  input logic               rst,
  password_lock_n_if.slave  lock_if
);
  localparam int unsigned TriesW = $clog2(MAX_TRIES + 1);
  localparam int unsigned IdxW   = $clog2(DIGITS + 1);
  localparam int unsigned MaxCyc = (LOCK_CYCLES > OPEN_CYCLES) ? LOCK_CYCLES : OPEN_CYCLES;
  localparam int unsigned TimerW = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;
  localparam int unsigned TopSh  = (TimerW >= 4) ? TimerW - 4 : 0;

  localparam logic [6:0] GlyphE     = 7'b0000110;
  localparam logic [6:0] GlyphR     = 7'b0101111;
  localparam logic [6:0] GlyphLo    = 7'b0100011;
  localparam logic [6:0] GlyphO     = 7'b1000000;
  localparam logic [6:0] GlyphP     = 7'b0001100;
  localparam logic [6:0] GlyphN     = 7'b0101011;
  localparam logic [6:0] GlyphL     = 7'b1000111;
  localparam logic [6:0] GlyphC     = 7'b1000110;
  localparam logic [6:0] GlyphDash  = 7'b0111111;
  localparam logic [6:0] GlyphBlank = 7'b1111111;

  typedef enum logic [2:0] {StIdle, StEntry, StCheck, StOpen, StError, StLockout} state_e;

  state_e            state_q;
  logic [TriesW-1:0] tries_q;
  logic [IdxW-1:0]   idx_q;
  logic              mismatch_q;
  logic [TimerW-1:0] timer_q;
  logic              unlocked_q;
  logic              locked_out_q;

  // Button: two-flop synchroniser plus a delay flop for rising-edge detection.
  logic sync1_q, sync2_q, dly_q, press;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dly_q   <= 1'b0;
    end else begin
      sync1_q <= lock_if.boton;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
    end
  end

  assign press = sync2_q & ~dly_q;

  // Expected entry for the current position; constant indices keep the slice in range.
  logic [DIG_W-1:0] pw_entry;
  always_comb begin
    pw_entry = '0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (idx_q == IdxW'(k)) pw_entry = PASSWORD[k*DIG_W +: DIG_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      tries_q      <= TriesW'(MAX_TRIES);
      idx_q        <= '0;
      mismatch_q   <= 1'b0;
      timer_q      <= '0;
      unlocked_q   <= 1'b0;
      locked_out_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (press) begin
            state_q    <= StEntry;
            idx_q      <= '0;
            mismatch_q <= 1'b0;
          end
        end
        StEntry: begin
          // Wrong entries are only remembered; the full code is always collected.
          if (press) begin
            mismatch_q <= mismatch_q | (lock_if.sw != pw_entry);
            idx_q      <= idx_q + IdxW'(1);
            if (idx_q == IdxW'(DIGITS - 1)) state_q <= StCheck;
          end
        end
        StCheck: begin
          if (!mismatch_q) begin
            state_q    <= StOpen;
            tries_q    <= TriesW'(MAX_TRIES);
            timer_q    <= TimerW'(OPEN_CYCLES - 1);
            unlocked_q <= 1'b1;
          end else if (tries_q == TriesW'(1)) begin
            state_q      <= StLockout;
            tries_q      <= '0;
            timer_q      <= TimerW'(LOCK_CYCLES - 1);
            locked_out_q <= 1'b1;
          end else begin
            state_q <= StError;
            tries_q <= tries_q - TriesW'(1);
          end
        end
        StOpen: begin
          if (press || timer_q == '0) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            unlocked_q <= 1'b0;
          end else begin
            timer_q <= timer_q - TimerW'(1);
          end
        end
        StError: begin
          if (press) begin
            state_q <= StIdle;
            idx_q   <= '0;
          end
        end
        StLockout: begin
          // Presses are dropped here, not queued.
          if (timer_q == '0) begin
            state_q      <= StIdle;
            tries_q      <= TriesW'(MAX_TRIES);
            idx_q        <= '0;
            locked_out_q <= 1'b0;
          end else begin
            timer_q <= timer_q - TimerW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    case (v)
      4'h0:    hex_glyph = 7'b1000000;
      4'h1:    hex_glyph = 7'b1111001;
      4'h2:    hex_glyph = 7'b0100100;
      4'h3:    hex_glyph = 7'b0110000;
      4'h4:    hex_glyph = 7'b0011001;
      4'h5:    hex_glyph = 7'b0010010;
      4'h6:    hex_glyph = 7'b0000010;
      4'h7:    hex_glyph = 7'b1111000;
      4'h8:    hex_glyph = 7'b0000000;
      4'h9:    hex_glyph = 7'b0010000;
      4'hA:    hex_glyph = 7'b0001000;
      4'hB:    hex_glyph = 7'b0000011;
      4'hC:    hex_glyph = 7'b1000110;
      4'hD:    hex_glyph = 7'b0100001;
      4'hE:    hex_glyph = 7'b0000110;
      default: hex_glyph = 7'b0001110;
    endcase
  endfunction

  logic [3:0] timer_top;
  assign timer_top = 4'(timer_q >> TopSh);

  logic [6:0] seg [5];
  always_comb begin
    for (int i = 0; i < 5; i++) seg[i] = GlyphDash;
    case (state_q)
      StEntry, StCheck: begin
        seg[4] = hex_glyph(4'(tries_q));
        seg[3] = GlyphBlank;
        seg[2] = GlyphBlank;
        seg[1] = GlyphBlank;
        seg[0] = hex_glyph(4'(idx_q));
      end
      StOpen: begin
        seg[4] = GlyphBlank;
        seg[3] = GlyphO;
        seg[2] = GlyphP;
        seg[1] = GlyphE;
        seg[0] = GlyphN;
      end
      StError: begin
        seg[4] = GlyphE;
        seg[3] = GlyphR;
        seg[2] = GlyphR;
        seg[1] = GlyphLo;
        seg[0] = GlyphR;
      end
      StLockout: begin
        seg[4] = GlyphL;
        seg[3] = GlyphO;
        seg[2] = GlyphC;
        seg[1] = GlyphBlank;
        seg[0] = hex_glyph(timer_top);
      end
      default: ;
    endcase
  end

  assign lock_if.unlocked   = unlocked_q;
  assign lock_if.locked_out = locked_out_q;
  assign lock_if.tries_left = tries_q;
  assign lock_if.digit_idx  = idx_q;
  assign lock_if.HEX0       = seg[0];
  assign lock_if.HEX1       = seg[1];
  assign lock_if.HEX2       = seg[2];
  assign lock_if.HEX3       = seg[3];
  assign lock_if.HEX4       = seg[4];
endmodule

// File: tb/tb_password_lock_n.sv
module tb_password_lock_n;
  localparam logic [15:0] Good  = 16'h3A5C;
  localparam logic [15:0] Wrong = 16'h3A50;

  localparam logic [6:0] GE = 7'b0000110, GR = 7'b0101111, GLo = 7'b0100011;
  localparam logic [6:0] GO = 7'b1000000, GP = 7'b0001100, GN = 7'b0101011;
  localparam logic [6:0] GL = 7'b1000111, GC = 7'b1000110, GD = 7'b0111111;
  localparam logic [6:0] GB = 7'b1111111;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  password_lock_n_if #(.DIGITS(4), .DIG_W(4), .MAX_TRIES(3)) lock_if ();

  password_lock_n #(
    .DIGITS(4), .DIG_W(4), .PASSWORD(16'h3A5C), .MAX_TRIES(3),
    .LOCK_CYCLES(20), .OPEN_CYCLES(30)
  ) dut (
    .clk(clk),
    .rst(rst),
    .lock_if(lock_if)
  );

  typedef struct {
    string       tag;
    logic        unl;
    logic        lko;
    logic [1:0]  tries;
    logic [2:0]  idx;
    logic        idx_chk;
    logic [34:0] hex;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic logic [6:0] dig(input int v);
    case (v)
      0: dig = 7'b1000000;  1: dig = 7'b1111001;  2: dig = 7'b0100100;
      3: dig = 7'b0110000;  4: dig = 7'b0011001;  5: dig = 7'b0010010;
      6: dig = 7'b0000010;  7: dig = 7'b1111000;  8: dig = 7'b0000000;
      9: dig = 7'b0010000;  default: dig = 7'b1111111;
    endcase
  endfunction

  function automatic logic [34:0] h_idle();
    return {GD, GD, GD, GD, GD};
  endfunction
  function automatic logic [34:0] h_entry(input int t, input int i);
    return {dig(t), GB, GB, GB, dig(i)};
  endfunction
  function automatic logic [34:0] h_open();
    return {GB, GO, GP, GE, GN};
  endfunction
  function automatic logic [34:0] h_err();
    return {GE, GR, GR, GLo, GR};
  endfunction
  function automatic logic [34:0] h_lock(input int v);
    return {GL, GO, GC, GB, dig(v)};
  endfunction

  task automatic push_exp(input string tag, input logic unl, input logic lko,
                          input int tr, input int ix, input logic ix_chk, input logic [34:0] hx);
    exp_t e;
    e.tag = tag; e.unl = unl; e.lko = lko; e.tries = 2'(tr); e.idx = 3'(ix);
    e.idx_chk = ix_chk; e.hex = hx;
    sb_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 64'(sb_q.size()), 64'd1);
      return;
    end
    e = sb_q.pop_front();
    chk({e.tag, ".unlocked"}, 64'(lock_if.unlocked), 64'(e.unl));
    chk({e.tag, ".locked_out"}, 64'(lock_if.locked_out), 64'(e.lko));
    chk({e.tag, ".tries_left"}, 64'(lock_if.tries_left), 64'(e.tries));
    if (e.idx_chk) chk({e.tag, ".digit_idx"}, 64'(lock_if.digit_idx), 64'(e.idx));
    chk({e.tag, ".hex"}, 64'({lock_if.HEX4, lock_if.HEX3, lock_if.HEX2, lock_if.HEX1,
                              lock_if.HEX0}), 64'(e.hex));
  endtask

  task automatic expect_now(input string tag, input logic unl, input logic lko,
                            input int tr, input int ix, input logic ix_chk,
                            input logic [34:0] hx);
    push_exp(tag, unl, lko, tr, ix, ix_chk, hx);
    pop_check();
  endtask

  // Called at a negedge; returns at the negedge right after the edge that acts on the press.
  task automatic press(input logic [3:0] v);
    lock_if.sw    = v;
    lock_if.boton = 1'b1;
    repeat (3) @(negedge clk);
    lock_if.boton = 1'b0;
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  // Start an attempt and enter all four entries; returns in CHECK.
  task automatic enter_code(input logic [15:0] code, input int tr);
    press(4'h0);
    expect_now("start", 1'b0, 1'b0, tr, 0, 1'b1, h_entry(tr, 0));
    settle();
    for (int i = 0; i < 4; i++) begin
      press(code[i*4 +: 4]);
      expect_now((i == 3) ? "check" : "entry", 1'b0, 1'b0, tr, i + 1, 1'b1, h_entry(tr, i + 1));
      if (i < 3) settle();
    end
  endtask

  // Wrong attempt from IDLE; ends in IDLE (via ERROR) or in LOCKOUT at its first cycle.
  task automatic fail_attempt(input int tr);
    enter_code(Wrong, tr);
    @(negedge clk);
    if (tr > 1) begin
      expect_now("error", 1'b0, 1'b0, tr - 1, 4, 1'b1, h_err());
      settle();
      press(4'h0);
      expect_now("err_to_idle", 1'b0, 1'b0, tr - 1, 0, 1'b1, h_idle());
      settle();
    end else begin
      // Timer starts at LOCK_CYCLES-1 = 19; top four of five bits = 9.
      expect_now("lockout", 1'b0, 1'b1, 0, 4, 1'b1, h_lock(9));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    lock_if.boton = 1'b0;
    lock_if.sw    = 4'h0;
    #3;
    expect_now("reset", 1'b0, 1'b0, 3, 0, 1'b1, h_idle());
    repeat (2) @(negedge clk);
    rst = 1'b0;
    settle();

    // Correct code, then auto-relock after 30 cycles in OPEN.
    enter_code(Good, 3);
    @(negedge clk);
    expect_now("open", 1'b1, 1'b0, 3, 4, 1'b1, h_open());
    repeat (29) @(negedge clk);
    expect_now("open_last", 1'b1, 1'b0, 3, 4, 1'b1, h_open());
    @(negedge clk);
    expect_now("relock", 1'b0, 1'b0, 3, 0, 1'b1, h_idle());
    settle();

    // Wrong first entry, then exhaust tries into lockout.
    fail_attempt(3);
    fail_attempt(2);
    fail_attempt(1);
    press(4'h5);   // three cycles into lockout: timer 16, top bits 8
    expect_now("lock_press", 1'b0, 1'b1, 0, 4, 1'b1, h_lock(8));
    repeat (16) @(negedge clk);
    expect_now("lock_last", 1'b0, 1'b1, 0, 4, 1'b1, h_lock(0));
    @(negedge clk);
    expect_now("lock_exit", 1'b0, 1'b0, 3, 0, 1'b0, h_idle());
    repeat (4) @(negedge clk);
    expect_now("no_queued", 1'b0, 1'b0, 3, 0, 1'b0, h_idle());

    // Held button gives exactly one press.
    lock_if.boton = 1'b1;
    repeat (100) @(negedge clk);
    expect_now("held", 1'b0, 1'b0, 3, 0, 1'b1, h_entry(3, 0));
    lock_if.boton = 1'b0;
    settle();
    repeat (5) @(negedge clk);
    expect_now("held_after", 1'b0, 1'b0, 3, 0, 1'b1, h_entry(3, 0));

    // Asynchronous reset mid-entry.
    press(4'hC);
    settle();
    press(4'h5);
    expect_now("mid_entry", 1'b0, 1'b0, 3, 2, 1'b1, h_entry(3, 2));
    #2 rst = 1'b1;
    #1 expect_now("rst_entry", 1'b0, 1'b0, 3, 0, 1'b1, h_idle());
    @(negedge clk);
    rst = 1'b0;
    settle();

    // Asynchronous reset mid-lockout restores tries.
    fail_attempt(3);
    fail_attempt(2);
    fail_attempt(1);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1 expect_now("rst_lock", 1'b0, 1'b0, 3, 0, 1'b1, h_idle());
    @(negedge clk);
    rst = 1'b0;
    settle();

    // Press coinciding with the OPEN timeout: one transition to IDLE only.
    fail_attempt(3);
    enter_code(Good, 2);
    @(negedge clk);
    expect_now("open2", 1'b1, 1'b0, 3, 4, 1'b1, h_open());
    repeat (27) @(negedge clk);
    lock_if.boton = 1'b1;
    repeat (2) @(negedge clk);
    expect_now("open2_last", 1'b1, 1'b0, 3, 4, 1'b1, h_open());
    @(negedge clk);
    expect_now("open2_exit", 1'b0, 1'b0, 3, 0, 1'b1, h_idle());
    lock_if.boton = 1'b0;
    repeat (4) @(negedge clk);
    expect_now("no_spurious", 1'b0, 1'b0, 3, 0, 1'b1, h_idle());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
